// File: rtl/upe_negate_seq.sv
// Sequential two's-complement negate / pass / absolute-value unit.
// The increment ripples through one CHUNK-wide slice per cycle, LSB slice first.
module upe_negate_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] In,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] op_reg;
  logic [WIDTH-1:0] res_reg;
  logic [IW-1:0]    idx;
  logic             carry;
  logic             ovf_reg;
  logic             accept;
  logic             do_neg;
  logic [CHUNK:0]   chunk_sum;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = BUSY;
      end
      BUSY: begin
        if (idx == LAST) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Negation is ~In + 1: invert at capture, then ripple the +1 as the initial carry.
  assign accept    = (state == IDLE) && in_valid;
  assign do_neg    = (mode == 2'b00) || ((mode == 2'b10) && In[WIDTH-1]);
  assign chunk_sum = {1'b0, op_reg[32'(idx)*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, carry};

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg  <= '0;
      res_reg <= '0;
      idx     <= '0;
      carry   <= 1'b0;
      ovf_reg <= 1'b0;
    end else if (accept) begin
      op_reg  <= do_neg ? ~In : In;
      carry   <= do_neg;
      idx     <= '0;
      ovf_reg <= do_neg && (In == MOST_NEG);
    end else if (state == BUSY) begin
      // Carry out of the top slice lands in carry and is never used again.
      res_reg[32'(idx)*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
      carry <= chunk_sum[CHUNK];
      idx   <= (idx == LAST) ? '0 : idx + IW'(1);
    end
  end

  assign Out      = res_reg;
  assign overflow = ovf_reg;

endmodule
